// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bridge_pkg
//  Description : Shared types and constants for the UART <-> CORDIC framing
//                bridge: FSM state encoding, default header bytes and the
//                payload byte-count derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

    // Bridge FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RX     = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_TX     = 3'd4,
        S_TXW    = 3'd5
    } state_e;

    localparam logic [7:0] HDR_REQ_DEFAULT = 8'h55;
    localparam logic [7:0] HDR_RSP_DEFAULT = 8'hAA;

    // Number of payload bytes carried by a WIDTH-bit operand/result
    function automatic int unsigned bytes_of(input int unsigned width);
        return width / 8;
    endfunction

endpackage : uart_bridge_pkg
`default_nettype wire

// File: rtl/uart_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_gap_timer
//  Description : Inter-byte gap counter. Restarts on every received byte,
//                counts while enabled and flags expiry after TIMEOUT cycles
//                without a byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_gap_timer #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The cycle carrying the byte is itself the first gap cycle, so a restart
    // loads 1; expiry at TIMEOUT-1 then lands exactly TIMEOUT cycles after the
    // byte once the FSM registers its error pulse. A byte in the expiry cycle
    // takes priority and restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = CW'(1);
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_gap_timer
`default_nettype wire

// File: rtl/uart_cordic_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cordic_bridge
//  Description : Collects a framed operand from the UART RX byte stream,
//                launches one CORDIC computation and returns the framed
//                result over the UART TX handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cordic_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter logic [7:0]  HDR_REQ = HDR_REQ_DEFAULT,
    parameter logic [7:0]  HDR_RSP = HDR_RSP_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_done_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_start_o,
    input  logic             tx_done_i,
    output logic [WIDTH-1:0] op_data_o,
    output logic             op_start_o,
    input  logic [WIDTH-1:0] res_data_i,
    input  logic             res_valid_i,
    output logic             busy_o,
    output logic             frame_err_o
);

    localparam int unsigned BYTES = bytes_of(WIDTH);
    localparam int unsigned RCW   = $clog2(BYTES + 1);
    localparam int unsigned TIW   = $clog2(BYTES + 2);

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [RCW-1:0]   rx_cnt_q,   rx_cnt_d;
    logic [WIDTH-1:0] op_data_q,  op_data_d;
    logic             op_start_q, op_start_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [TIW-1:0]   tx_idx_q,   tx_idx_d;
    logic [7:0]       tx_data_q,  tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             frame_err_q, frame_err_d;
    logic             gap_expired;

    uart_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (state_q == S_RX),
        .restart_i (rx_done_i),
        .expired_o (gap_expired)
    );

    // Next-state and registered-output logic for the framing FSM
    always_comb begin
        state_d     = state_q;
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        op_data_d   = op_data_q;
        op_start_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        tx_idx_d    = tx_idx_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Anything other than the request header is line noise
                if (rx_done_i && (rx_data_i == HDR_REQ)) begin
                    state_d    = S_RX;
                    rx_cnt_d   = '0;
                    rx_shift_d = '0;
                end
            end
            S_RX: begin
                if (rx_done_i) begin
                    rx_shift_d = (rx_shift_q << 8) | WIDTH'(rx_data_i);
                    rx_cnt_d   = rx_cnt_q + RCW'(1);
                    if (rx_cnt_q == RCW'(BYTES - 1)) begin
                        state_d = S_LAUNCH;
                    end
                end else if (gap_expired) begin
                    // Partial operand is abandoned; op_data keeps last launch
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            S_LAUNCH: begin
                op_data_d  = rx_shift_q;
                op_start_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (res_valid_i) begin
                    tx_shift_d = res_data_i;
                    tx_idx_d   = '0;
                    state_d    = S_TX;
                end
            end
            S_TX: begin
                tx_start_d = 1'b1;
                if (tx_idx_q == '0) begin
                    tx_data_d = HDR_RSP;
                end else begin
                    tx_data_d  = tx_shift_q[WIDTH-1 -: 8];
                    tx_shift_d = tx_shift_q << 8;
                end
                tx_idx_d = tx_idx_q + TIW'(1);
                state_d  = S_TXW;
            end
            S_TXW: begin
                // tx_idx counts bytes already handed over, header included
                if (tx_done_i) begin
                    state_d = (tx_idx_q == TIW'(BYTES + 1)) ? S_IDLE : S_TX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bytes arriving while a computation or response is in flight are lost
        if (rx_done_i && (state_q inside {S_LAUNCH, S_WAIT, S_TX, S_TXW})) begin
            frame_err_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            rx_shift_q  <= '0;
            rx_cnt_q    <= '0;
            op_data_q   <= '0;
            op_start_q  <= 1'b0;
            tx_shift_q  <= '0;
            tx_idx_q    <= '0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            op_data_q   <= op_data_d;
            op_start_q  <= op_start_d;
            tx_shift_q  <= tx_shift_d;
            tx_idx_q    <= tx_idx_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign op_data_o   = op_data_q;
    assign op_start_o  = op_start_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule : uart_cordic_bridge
`default_nettype wire

// File: doc/uart_cordic_bridge.md
# uart_cordic_bridge

Byte-level framing stage directly downstream of the UART receiver and upstream of its transmitter. It collects a framed operand from the UART RX byte stream, launches one computation on the CORDIC exponential core, and returns the framed result over the UART TX handshake. It is the only path between the serial link and the core.

## Interface
- `WIDTH`, 32: operand/result width in bits; must be a multiple of 8.
- `TIMEOUT`, 1_000_000: maximum CLK cycles between payload bytes before the frame is aborted.
- `HDR_REQ`, 8'h55: request header byte.
- `HDR_RSP`, 8'hAA: response header byte.

- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `RX_DATA`  in  8  received byte; valid when `RX_DONE`=1.
- `RX_DONE`  in  1  one-cycle pulse per received byte.
- `TX_DATA`  out  8  byte to transmit; held stable from `TX_START` until `TX_DONE`.
- `TX_START`  out  1  one-cycle pulse requesting transmission of `TX_DATA`.
- `TX_DONE`  in  1  one-cycle pulse when the transmitter finishes a byte.
- `OP_DATA`  out  WIDTH  operand to the core; stable from `OP_START` until the next frame is accepted.
- `OP_START`  out  1  one-cycle launch pulse to the core.
- `RES_DATA`  in  WIDTH  core result; valid when `RES_VALID`=1.
- `RES_VALID`  in  1  one-cycle pulse when the result is ready.
- `BUSY`  out  1  high in every state other than S_IDLE.
- `FRAME_ERR`  out  1  one-cycle pulse on gap timeout or overrun.

## Operation
- Request frame: `HDR_REQ`, then WIDTH/8 payload bytes, MSB first. Response frame: `HDR_RSP`, then WIDTH/8 result bytes, MSB first.
- FSM states:
  - S_IDLE: on `RX_DONE` with `RX_DATA`==`HDR_REQ`, go to S_RX with the byte count cleared. Any other byte is silently ignored, with no error.
  - S_RX: each `RX_DONE` shifts the byte into the operand shift register, LSB end, and increments the count. After the last byte, go to S_LAUNCH.
  - S_LAUNCH: drive `OP_DATA` from the shift register, pulse `OP_START`, go to S_WAIT.
  - S_WAIT: on `RES_VALID`, latch `RES_DATA` into the TX shift register, then go to S_TX.
  - S_TX: drive `TX_DATA` (header first, then result bytes MSB first), pulse `TX_START`, go to S_TXW.
  - S_TXW: on `TX_DONE`, return to S_TX if bytes remain; otherwise go to S_IDLE.
- Gap timer runs only in S_RX:
  - It clears on entry and on every `RX_DONE`.
  - When it reaches `TIMEOUT`-1 with no byte, go to S_IDLE and pulse `FRAME_ERR`. The partial operand is discarded and `OP_DATA` is unchanged.
- Overrun: an `RX_DONE` in S_LAUNCH, S_WAIT, S_TX or S_TXW drops the byte and pulses `FRAME_ERR`. The state is unaffected.
- `RES_VALID` outside S_WAIT is ignored. `TX_DONE` outside S_TXW is ignored.
- No computation timeout: S_WAIT waits for the core indefinitely.

## Timing
- Reset values: `TX_DATA`=8'h00, `TX_START`=0, `OP_DATA`=0, `OP_START`=0, `BUSY`=0, `FRAME_ERR`=0. The FSM resets to S_IDLE and all counters to 0.
- `RST` assertion mid-frame or mid-transmission aborts immediately. Any byte already handed to the transmitter completes outside this block's control.
- Last payload `RX_DONE` at cycle N:
  - `OP_START` is high at N+2 (S_RX→S_LAUNCH at N+1, pulse registered at N+2).
  - `OP_DATA` is valid no later than N+2.
- `RES_VALID` at cycle M: first `TX_START` at M+2, with `TX_DATA`=`HDR_RSP`.
- `TX_DONE` at cycle K with bytes remaining: next `TX_START` at K+2.
- Gap timer: `RX_DONE` and timer expiry in the same cycle → the byte wins and the timer clears.
- `BUSY` rises the cycle after the header is accepted. It falls the cycle after the final `TX_DONE`.

## Structure
- Package `uart_bridge_pkg`: FSM state encodings, `HDR_REQ`/`HDR_RSP` defaults, and the `BYTES`=WIDTH/8 derivation.
- Sub-module `uart_gap_timer`: load-clear counter with an expiry output, parameterised by `TIMEOUT`. Everything else stays in the top FSM.

## Test plan
- RX 55 01 02 03 04 → `OP_DATA`=32'h01020304 and a single `OP_START` pulse. Core returns 32'hDEADBEEF → TX sequence AA, DE, AD, BE, EF, with each `TX_START` 2 cycles after the prior `TX_DONE`.
- RX 12 34 then 55 00 00 00 01 → the first two bytes are ignored, no `FRAME_ERR`, `OP_DATA`=32'h00000001.
- With `TIMEOUT`=100: RX 55 01 02, then silence → `FRAME_ERR` pulse exactly 100 cycles after the 02 byte, `BUSY`=0. A following full frame processes normally.
- RX byte 7F during S_WAIT → one `FRAME_ERR` pulse, the byte is dropped, and the response frame is unaffected.
- `RST` low during the third response byte → all outputs take reset values asynchronously. After release, a new frame 55 00 00 00 02 completes normally.
- Byte arrives in the same cycle as timer expiry → no `FRAME_ERR` and the frame continues.
